// File: rtl/jogador_automatico_pkg.sv
// Shared constants for the autonomous memory-game player: FSM state codes,
// the "never inject an error" marker and small one-hot helpers.
package jogador_automatico_pkg;

    // FSM state codes (also shown on db_estado)
    localparam logic [2:0] INICIAL     = 3'd0;
    localparam logic [2:0] PULSO_JOGAR = 3'd1;
    localparam logic [2:0] ESPERA      = 3'd2;
    localparam logic [2:0] AMOSTRA     = 3'd3;
    localparam logic [2:0] PRESSIONA   = 3'd4;
    localparam logic [2:0] SOLTA       = 3'd5;
    localparam logic [2:0] FIM         = 3'd6;

    // erro_em value meaning "always press the right button"
    localparam logic [3:0] ERRO_NUNCA = 4'hF;

    // True when exactly one bit of v is set
    function automatic logic um_quente(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Rotate left by one: 0001->0010, 1000->0001 (wrong-button generator)
    function automatic logic [3:0] rot_esq(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/jogador_automatico_contador_m.sv
// Modulo-M counter with synchronous clear (zera has priority over conta)
// and a terminal-count flag (fim) that is high while the count is M-1.
module contador_m #(
    parameter int M = 8,
    parameter int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] valor_q;

    // Count register: clear, hold or advance with wrap at M-1
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) begin
            valor_q <= '0;
        end else if (zera) begin
            valor_q <= '0;
        end else if (conta) begin
            valor_q <= (valor_q == ULTIMO) ? '0 : valor_q + 1'b1;
        end
    end

    assign fim = (valor_q == ULTIMO);

endmodule

// File: rtl/jogador_automatico.sv
// Autonomous player for jogo_desafio_memoria: pulses jogar, then repeatedly
// waits, samples the game's LEDs, presses the matching button for
// HOLD_CICLOS cycles and releases it, until the game reports pronto.
// erro_em selects a play index at which the wrong button is pressed.
module jogador_automatico
    import jogador_automatico_pkg::*;
#(
    parameter int HOLD_CICLOS   = 4,
    parameter int ESPERA_CICLOS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] erro_em,
    input  logic [3:0] leds,
    input  logic       pronto,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic       fim,
    output logic       resultado,
    output logic [3:0] db_jogadas,
    output logic [3:0] db_estado
);

    logic [2:0] estado_q, estado_d;
    logic [3:0] botao_q, botao_d;
    logic [3:0] jogadas_q, jogadas_d;
    logic       resultado_q, resultado_d;
    logic       jogar_q, ocupado_q, fim_q;
    logic [3:0] botoes_q;
    logic       espera_fim, hold_fim;
    logic       ativo;

    // Timers are held at zero outside their state, so each entry starts at 0
    contador_m #(.M(ESPERA_CICLOS)) u_timer_espera (
        .clock (clock),
        .reset (reset),
        .zera  (estado_q != ESPERA),
        .conta (estado_q == ESPERA),
        .fim   (espera_fim)
    );

    contador_m #(.M(HOLD_CICLOS)) u_timer_hold (
        .clock (clock),
        .reset (reset),
        .zera  (estado_q != PRESSIONA),
        .conta (estado_q == PRESSIONA),
        .fim   (hold_fim)
    );

    // States in which game completion is watched
    assign ativo = (estado_q == ESPERA) || (estado_q == AMOSTRA) ||
                   (estado_q == PRESSIONA) || (estado_q == SOLTA);

    // Next-state, button latch, press counter and result logic
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        estado_d    = estado_q;
        botao_d     = botao_q;
        jogadas_d   = jogadas_q;
        resultado_d = resultado_q;

        case (estado_q)
            INICIAL, FIM: begin
                if (iniciar) begin
                    estado_d    = PULSO_JOGAR;
                    jogadas_d   = 4'd0;
                    resultado_d = 1'b0;
                end
            end
            PULSO_JOGAR: estado_d = ESPERA;
            ESPERA: begin
                if (espera_fim) estado_d = AMOSTRA;
            end
            AMOSTRA: begin
                if (um_quente(leds)) begin
                    botao_d  = (erro_em != ERRO_NUNCA && jogadas_q == erro_em)
                               ? rot_esq(leds) : leds;
                    estado_d = PRESSIONA;
                end else begin
                    estado_d = ESPERA;
                end
            end
            PRESSIONA: begin
                if (hold_fim) estado_d = SOLTA;
            end
            SOLTA: begin
                if (jogadas_q != 4'hF) jogadas_d = jogadas_q + 4'd1;
                estado_d = ESPERA;
            end
            default: estado_d = INICIAL;
        endcase

        // Game over wins over timers and any pending press
        if (pronto && ativo) begin
            estado_d    = FIM;
            resultado_d = ganhou;
        end
    end

    // State and registered (Moore) outputs decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= INICIAL;
            botao_q     <= 4'd0;
            jogadas_q   <= 4'd0;
            resultado_q <= 1'b0;
            jogar_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            fim_q       <= 1'b0;
            botoes_q    <= 4'd0;
        end else begin
            estado_q    <= estado_d;
            botao_q     <= botao_d;
            jogadas_q   <= jogadas_d;
            resultado_q <= resultado_d;
            jogar_q     <= (estado_d == PULSO_JOGAR);
            ocupado_q   <= (estado_d >= PULSO_JOGAR) && (estado_d <= SOLTA);
            fim_q       <= (estado_d == FIM);
            botoes_q    <= (estado_d == PRESSIONA) ? botao_d : 4'd0;
        end
    end

    assign jogar      = jogar_q;
    assign botoes     = botoes_q;
    assign ocupado    = ocupado_q;
    assign fim        = fim_q;
    assign resultado  = resultado_q;
    assign db_jogadas = jogadas_q;
    assign db_estado  = {1'b0, estado_q};

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: stimulus pushes the expected
// jogar pulses, button presses (value and hold length) and end-of-game
// results; a negedge monitor pops and compares as the DUT produces them.
module tb_jogador_automatico;

    typedef enum logic [1:0] {EV_JOGAR = 2'd0, EV_PRESS = 2'd1, EV_FIM = 2'd2} ev_tipo_t;
    typedef struct packed {
        ev_tipo_t   tipo;
        logic [3:0] valor;
        logic [7:0] dur;
    } evento_t;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] erro_em;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu;
    logic       jogar, ocupado, fim, resultado;
    logic [3:0] botoes, db_jogadas, db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    evento_t exp_q[$];
    evento_t ev_mon;
    logic [3:0] botoes_ant = 4'd0;
    logic       fim_ant    = 1'b0;
    logic [7:0] dur_atual  = 8'd0;
    logic [7:0] dur_esp    = 8'd0;

    jogador_automatico #(.HOLD_CICLOS(4), .ESPERA_CICLOS(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .erro_em    (erro_em),
        .leds       (leds),
        .pronto     (pronto),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .jogar      (jogar),
        .botoes     (botoes),
        .ocupado    (ocupado),
        .fim        (fim),
        .resultado  (resultado),
        .db_jogadas (db_jogadas),
        .db_estado  (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic espera_evento(input ev_tipo_t tipo, input logic [3:0] valor, input logic [7:0] dur);
        evento_t e;
        e.tipo  = tipo;
        e.valor = valor;
        e.dur   = dur;
        exp_q.push_back(e);
    endtask

    // Bounded wait for a given state code and press count
    task automatic esperar_estado(input logic [3:0] est, input logic [3:0] jog, input int limite, input string nome);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limite && !ok; i++) begin
            tick();
            if (db_estado == est && db_jogadas == jog) ok = 1'b1;
        end
        check(nome, 32'(ok), 32'd1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clock) begin
        if (jogar) begin
            if (exp_q.size() == 0) begin
                check("jogar inesperado", 32'd1, 32'd0);
            end else begin
                ev_mon = exp_q.pop_front();
                check("ordem evento jogar", 32'(EV_JOGAR), 32'(ev_mon.tipo));
            end
        end
        if (botoes != 4'd0 && botoes_ant == 4'd0) begin
            if (exp_q.size() == 0) begin
                check("press inesperado", 32'(botoes), 32'd0);
            end else begin
                ev_mon = exp_q.pop_front();
                check("ordem evento press", 32'(EV_PRESS), 32'(ev_mon.tipo));
                check("botoes", 32'(botoes), 32'(ev_mon.valor));
                dur_esp = ev_mon.dur;
            end
            dur_atual = 8'd1;
        end else if (botoes != 4'd0) begin
            dur_atual = dur_atual + 8'd1;
        end
        if (botoes == 4'd0 && botoes_ant != 4'd0)
            check("duracao press", 32'(dur_atual), 32'(dur_esp));
        if (fim && !fim_ant) begin
            if (exp_q.size() == 0) begin
                check("fim inesperado", 32'd1, 32'd0);
            end else begin
                ev_mon = exp_q.pop_front();
                check("ordem evento fim", 32'(EV_FIM), 32'(ev_mon.tipo));
                check("resultado", 32'(resultado), 32'(ev_mon.valor[0]));
            end
        end
        botoes_ant = botoes;
        fim_ant    = fim;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit so_espera;
        bit viu_amostra;

        reset   = 1'b1;
        iniciar = 1'b0;
        erro_em = 4'hF;
        leds    = 4'b0100;
        pronto  = 1'b0;
        ganhou  = 1'b0;
        perdeu  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst botoes", 32'(botoes), 32'd0);
        check("rst jogar", 32'(jogar), 32'd0);
        check("rst ocupado", 32'(ocupado), 32'd0);
        check("rst fim", 32'(fim), 32'd0);
        check("rst resultado", 32'(resultado), 32'd0);
        check("rst db_jogadas", 32'(db_jogadas), 32'd0);
        check("rst db_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        tick();
        check("idle db_estado", 32'(db_estado), 32'd0);

        // Round 1: correct press of 0100, then lose on the 2nd press
        espera_evento(EV_JOGAR, 4'd0, 8'd0);
        espera_evento(EV_PRESS, 4'b0100, 8'd4);
        espera_evento(EV_PRESS, 4'b0100, 8'd2);
        espera_evento(EV_FIM, 4'd0, 8'd0);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("pulso jogar", 32'(jogar), 32'd1);
        check("pulso ocupado", 32'(ocupado), 32'd1);
        check("pulso db_estado", 32'(db_estado), 32'd1);
        tick();
        check("espera jogar", 32'(jogar), 32'd0);
        check("espera db_estado", 32'(db_estado), 32'd2);
        check("espera ocupado", 32'(ocupado), 32'd1);
        repeat (8) tick();
        check("amostra db_estado", 32'(db_estado), 32'd3);
        check("amostra botoes", 32'(botoes), 32'd0);
        tick();
        check("pressiona db_estado", 32'(db_estado), 32'd4);
        check("pressiona botoes", 32'(botoes), 32'b0100);
        repeat (3) tick();
        check("pressiona fim botoes", 32'(botoes), 32'b0100);
        tick();
        check("solta db_estado", 32'(db_estado), 32'd5);
        check("solta botoes", 32'(botoes), 32'd0);
        check("solta ocupado", 32'(ocupado), 32'd1);
        tick();
        check("jogadas apos 1", 32'(db_jogadas), 32'd1);
        check("volta espera", 32'(db_estado), 32'd2);
        repeat (8) tick();
        check("amostra 2", 32'(db_estado), 32'd3);
        tick();
        tick();
        check("pressiona 2 ciclo 2", 32'(botoes), 32'b0100);
        pronto = 1'b1;
        perdeu = 1'b1;
        tick();
        pronto = 1'b0;
        perdeu = 1'b0;
        check("perdeu fim", 32'(fim), 32'd1);
        check("perdeu botoes", 32'(botoes), 32'd0);
        check("perdeu resultado", 32'(resultado), 32'd0);
        check("perdeu db_estado", 32'(db_estado), 32'd6);
        check("perdeu ocupado", 32'(ocupado), 32'd0);
        check("perdeu db_jogadas", 32'(db_jogadas), 32'd1);
        repeat (2) tick();
        check("fim retido", 32'(fim), 32'd1);

        // Round 2: error injected at play 0, then correct, then reset mid-press
        erro_em = 4'd0;
        leds    = 4'b1000;
        espera_evento(EV_JOGAR, 4'd0, 8'd0);
        espera_evento(EV_PRESS, 4'b0001, 8'd4);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("reinicio jogar", 32'(jogar), 32'd1);
        check("reinicio fim", 32'(fim), 32'd0);
        check("reinicio db_jogadas", 32'(db_jogadas), 32'd0);
        esperar_estado(4'd2, 4'd1, 40, "espera press erro");
        leds = 4'b0010;
        espera_evento(EV_PRESS, 4'b0010, 8'd4);
        esperar_estado(4'd2, 4'd2, 40, "espera press certo");
        erro_em = 4'hF;
        leds    = 4'b0100;
        espera_evento(EV_PRESS, 4'b0100, 8'd2);
        esperar_estado(4'd4, 4'd2, 40, "espera pressiona 3");
        tick();
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rst async botoes", 32'(botoes), 32'd0);
        check("rst async jogar", 32'(jogar), 32'd0);
        check("rst async fim", 32'(fim), 32'd0);
        check("rst async db_jogadas", 32'(db_jogadas), 32'd0);
        check("rst async db_estado", 32'(db_estado), 32'd0);
        check("rst async ocupado", 32'(ocupado), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("pos rst db_estado", 32'(db_estado), 32'd0);

        // Round 3: no one-hot LED for 30 cycles, then 0001 and a win
        leds = 4'b0000;
        espera_evento(EV_JOGAR, 4'd0, 8'd0);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        so_espera   = 1'b1;
        viu_amostra = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (db_estado != 4'd2 && db_estado != 4'd3) so_espera = 1'b0;
            if (db_estado == 4'd3) viu_amostra = 1'b1;
        end
        check("leds 0000 so espera/amostra", 32'(so_espera), 32'd1);
        check("leds 0000 amostrou", 32'(viu_amostra), 32'd1);
        check("leds 0000 sem press", 32'(db_jogadas), 32'd0);
        leds = 4'b0001;
        espera_evento(EV_PRESS, 4'b0001, 8'd4);
        esperar_estado(4'd2, 4'd1, 40, "espera press 0001");
        pronto = 1'b1;
        ganhou = 1'b1;
        espera_evento(EV_FIM, 4'd1, 8'd0);
        tick();
        pronto = 1'b0;
        ganhou = 1'b0;
        check("ganhou fim", 32'(fim), 32'd1);
        check("ganhou resultado", 32'(resultado), 32'd1);
        check("ganhou db_jogadas", 32'(db_jogadas), 32'd1);
        repeat (3) tick();
        check("ganhou retido", 32'(resultado), 32'd1);
        check("fila vazia", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Autonomous player for jogo_desafio_memoria; drives the game's jogar/botoes inputs from its leds/pronto/ganhou/perdeu outputs.
- Starts a round, samples the LED value shown by the game, presses the matching button, releases it, and repeats until the game signals pronto.
- Optional error injection at a chosen play index exercises the lose path.
- Used in FPGA demo mode and as a self-checking stimulus source in the game testbench.

Parameters:
- HOLD_CICLOS, 4, cycles a button is held pressed (>=2 so the game's edge detector registers it).
- ESPERA_CICLOS, 8, idle cycles between release and next LED sample (covers game address update latency); >=1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  level/pulse; starts autoplay when idle or finished
- erro_em  in  4  play index at which a wrong button is pressed; 4'hF = never
- leds  in  4  game LED output (one-hot expected value)
- pronto  in  1  game finished
- ganhou  in  1  game won
- perdeu  in  1  game lost
- jogar  out  1  one-cycle start pulse to game
- botoes  out  4  one-hot button drive to game
- ocupado  out  1  high from PULSO_JOGAR through SOLTA
- fim  out  1  high in FIM
- resultado  out  1  1 = game won, 0 = lost; valid while fim=1
- db_jogadas  out  4  presses issued this round, saturates at 15
- db_estado  out  4  current state code, for hexa7seg display

Behaviour:
- Reset (async, any state): state=INICIAL, jogar=0, botoes=0, ocupado=0, fim=0, resultado=0, db_jogadas=0, timers=0.
- State codes: INICIAL=0, PULSO_JOGAR=1, ESPERA=2, AMOSTRA=3, PRESSIONA=4, SOLTA=5, FIM=6; unused codes go to INICIAL.
- INICIAL: all outputs 0. iniciar=1 -> PULSO_JOGAR.
- PULSO_JOGAR (1 cycle): jogar=1, db_jogadas cleared, timer cleared -> ESPERA. jogar is high only in this state.
- ESPERA: timer counts 0..ESPERA_CICLOS-1; at terminal count -> AMOSTRA.
- AMOSTRA (1 cycle):
  - leds one-hot: latch the button. If db_jogadas==erro_em, latch leds rotated left by 1 (0001->0010, 1000->0001). -> PRESSIONA.
  - leds not one-hot (0000 or multi-bit): no press, timer cleared -> ESPERA.
- PRESSIONA: botoes=latched value for exactly HOLD_CICLOS cycles -> SOLTA.
- SOLTA (1 cycle): botoes=0; db_jogadas+1 (saturate 15) -> ESPERA, timer cleared.
- pronto=1 in ESPERA/AMOSTRA/PRESSIONA/SOLTA -> FIM next edge. Overrides timer and press; botoes forced 0 from the FIM cycle on.
- Entry to FIM: resultado <= ganhou sampled in the same cycle pronto is seen. If ganhou and perdeu are both 0 (timeout), resultado=0.
- FIM: fim=1, holds resultado and db_jogadas. iniciar=1 -> PULSO_JOGAR (restart).
- iniciar ignored in all states other than INICIAL and FIM.
- Output registration: botoes, jogar, fim, ocupado are registered (Moore, no combinational input->output path).

Decomposition:
- Shared package/header: state code constants, ERRO_NUNCA=4'hF.
- One sub-module: contador_m (modulo-M counter with zera/conta/fim), instantiated twice for the ESPERA and HOLD timers.
- The FSM and latch registers live in jogador_automatico.

Test Plan:
1. Reset asserted mid-PRESSIONA with botoes=0100 -> botoes, jogar, fim, db_jogadas = 0 immediately; db_estado=0.
2. iniciar pulse at cycle t -> jogar=1 only at t+1; ocupado=1 from t+1.
3. erro_em=F, leds=0100 steady -> after 8 ESPERA cycles + 1 AMOSTRA, botoes=0100 for exactly 4 cycles, then 0; db_jogadas=1.
4. erro_em=0, leds=1000 -> first press is botoes=0001. Second press (leds=0010) is correct: 0010.
5. pronto=1, perdeu=1 asserted on 2nd PRESSIONA cycle -> next cycle botoes=0, fim=1, resultado=0. Then iniciar -> jogar pulse, fim=0.
6. leds=0000 for 30 cycles -> botoes never nonzero; state cycles ESPERA/AMOSTRA. Then leds=0001, pronto, ganhou -> eventually fim=1, resultado=1.
